// File: rtl/z80fi_insn_tracker.sv
// Trace-only instruction tracker: watches core strobes, assembles one retired-instruction record
// and emits it as a single-cycle z80fi_valid packet two clocks after the instruction ends.
module z80fi_insn_tracker #(
  parameter int MAX_BYTES = 4,
  parameter int TCYC_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_insn_start,
  input  logic                   cpu_insn_end,
  input  logic                   cpu_mcycle_start,
  input  logic [2:0]             cpu_mcycle_type,
  input  logic                   cpu_tstate,
  input  logic                   cpu_fetch_valid,
  input  logic [7:0]             cpu_fetch_byte,
  input  logic [15:0]            cpu_reg_ip,
  input  logic [7:0]             cpu_reg_a,
  input  logic [7:0]             cpu_reg_r,
  output logic                   z80fi_valid,
  output logic [8*MAX_BYTES-1:0] z80fi_insn,
  output logic [2:0]             z80fi_insn_len,
  output logic [15:0]            z80fi_reg_ip_in,
  output logic [15:0]            z80fi_reg_ip_out,
  output logic [7:0]             z80fi_reg_a_in,
  output logic [7:0]             z80fi_reg_a_out,
  output logic [7:0]             z80fi_reg_r_in,
  output logic [7:0]             z80fi_reg_r_out,
  output logic [2:0]             z80fi_mcycle_type1,
  output logic [2:0]             z80fi_mcycle_type2,
  output logic [2:0]             z80fi_mcycle_type3,
  output logic [TCYC_W-1:0]      z80fi_tcycles1,
  output logic [TCYC_W-1:0]      z80fi_tcycles2,
  output logic [TCYC_W-1:0]      z80fi_tcycles3,
  output logic                   z80fi_overflow
);

  localparam logic [2:0]        CYCLE_NONE = 3'd0;
  localparam logic [2:0]        MAX_LEN    = 3'(MAX_BYTES);
  localparam logic [TCYC_W-1:0] T_MAX      = '1;

  // COMMIT_ACTIVE: a closed record awaits emission while the next one is already open.
  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT, COMMIT_ACTIVE} state_t;

  state_t state, state_nxt;
  logic   active, pending, close;

  // Working record.
  logic [8*MAX_BYTES-1:0]  w_bytes;
  logic [2:0]              w_len;
  logic                    w_ovf;
  logic [15:0]             w_ip_in;
  logic [7:0]              w_a_in, w_r_in;
  logic [2:0][2:0]         w_type;
  logic [2:0][TCYC_W-1:0]  w_tc;
  logic [2:0]              idx;   // 0: no slot open, 1..3: slot open, 4: beyond slot 3
  logic [TCYC_W-1:0]       tcnt;

  // Closed record waiting for its COMMIT cycle.
  logic [8*MAX_BYTES-1:0]  c_bytes;
  logic [2:0]              c_len;
  logic                    c_ovf;
  logic [15:0]             c_ip_in;
  logic [7:0]              c_a_in, c_r_in;
  logic [2:0][2:0]         c_type;
  logic [2:0][TCYC_W-1:0]  c_tc;

  // Working record after this cycle's fetch/tstate events.
  logic [8*MAX_BYTES-1:0]  f_bytes;
  logic [2:0]              f_len;
  logic                    f_ovf;
  logic [TCYC_W-1:0]       t_inc;
  logic [2:0][TCYC_W-1:0]  closed_tc;
  logic                    slot_open;
  logic [1:0]              slot_sel;

  assign active    = (state == ACTIVE) || (state == COMMIT_ACTIVE);
  assign pending   = (state == COMMIT) || (state == COMMIT_ACTIVE);
  assign close     = active && (cpu_insn_end || cpu_insn_start);
  assign slot_open = (idx >= 3'd1) && (idx <= 3'd3);
  assign slot_sel  = 2'(idx - 3'd1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = IDLE;
    unique case ({close, cpu_insn_start || (active && !cpu_insn_end)})
      2'b00:   state_nxt = IDLE;
      2'b01:   state_nxt = ACTIVE;
      2'b10:   state_nxt = COMMIT;
      default: state_nxt = COMMIT_ACTIVE;
    endcase
  end

  always_comb begin
    f_bytes = w_bytes;
    f_len   = w_len;
    f_ovf   = w_ovf;
    if (cpu_fetch_valid) begin
      if (w_len == MAX_LEN) begin
        f_ovf = 1'b1;
      end else begin
        f_bytes[8*w_len +: 8] = cpu_fetch_byte;
        f_len                 = w_len + 3'd1;
      end
    end
    t_inc     = (cpu_tstate && tcnt != T_MAX) ? tcnt + 1'b1 : tcnt;
    closed_tc = w_tc;
    if (slot_open) closed_tc[slot_sel] = t_inc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the working buffers are plain registers and are cleared on reset so no stale record survives.
    if (!reset_n) begin
      w_bytes <= '0;
      w_len   <= '0;
      w_ovf   <= 1'b0;
      w_ip_in <= '0;
      w_a_in  <= '0;
      w_r_in  <= '0;
      w_type  <= {3{CYCLE_NONE}};
      w_tc    <= '0;
      idx     <= '0;
      tcnt    <= '0;
    end else if (cpu_insn_start) begin
      w_bytes <= '0;
      w_len   <= '0;
      w_ovf   <= 1'b0;
      // A fetch in the opening cycle belongs to the closing record if one is active.
      if (!active && cpu_fetch_valid) begin
        w_bytes[7:0] <= cpu_fetch_byte;
        w_len        <= 3'd1;
      end
      w_ip_in <= cpu_reg_ip;
      w_a_in  <= cpu_reg_a;
      w_r_in  <= cpu_reg_r;
      w_type  <= {3{CYCLE_NONE}};
      w_tc    <= '0;
      if (cpu_mcycle_start) begin
        w_type[0] <= cpu_mcycle_type;
        idx       <= 3'd1;
        tcnt      <= TCYC_W'(cpu_tstate);
      end else begin
        idx  <= '0;
        tcnt <= '0;
      end
    end else if (active) begin
      w_bytes <= f_bytes;
      w_len   <= f_len;
      w_ovf   <= f_ovf;
      if (cpu_mcycle_start && !cpu_insn_end) begin
        if (slot_open)    w_tc[slot_sel]  <= tcnt;
        if (idx < 3'd3)   w_type[idx[1:0]] <= cpu_mcycle_type;
        if (idx != 3'd4)  idx <= idx + 3'd1;
        tcnt <= TCYC_W'(cpu_tstate);
      end else begin
        tcnt <= t_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_bytes <= '0;
      c_len   <= '0;
      c_ovf   <= 1'b0;
      c_ip_in <= '0;
      c_a_in  <= '0;
      c_r_in  <= '0;
      c_type  <= {3{CYCLE_NONE}};
      c_tc    <= '0;
    end else if (close) begin
      c_bytes <= f_bytes;
      c_len   <= f_len;
      // A start without an end aborts the running record.
      c_ovf   <= f_ovf || (cpu_insn_start && !cpu_insn_end);
      c_ip_in <= w_ip_in;
      c_a_in  <= w_a_in;
      c_r_in  <= w_r_in;
      c_type  <= w_type;
      c_tc    <= closed_tc;
    end
  end

  // The core commits on the insn_end edge, so the live registers are the *_out values during COMMIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z80fi_valid        <= 1'b0;
      z80fi_insn         <= '0;
      z80fi_insn_len     <= '0;
      z80fi_reg_ip_in    <= '0;
      z80fi_reg_ip_out   <= '0;
      z80fi_reg_a_in     <= '0;
      z80fi_reg_a_out    <= '0;
      z80fi_reg_r_in     <= '0;
      z80fi_reg_r_out    <= '0;
      z80fi_mcycle_type1 <= CYCLE_NONE;
      z80fi_mcycle_type2 <= CYCLE_NONE;
      z80fi_mcycle_type3 <= CYCLE_NONE;
      z80fi_tcycles1     <= '0;
      z80fi_tcycles2     <= '0;
      z80fi_tcycles3     <= '0;
      z80fi_overflow     <= 1'b0;
    end else begin
      z80fi_valid <= pending;
      if (pending) begin
        z80fi_insn         <= c_bytes;
        z80fi_insn_len     <= c_len;
        z80fi_reg_ip_in    <= c_ip_in;
        z80fi_reg_ip_out   <= cpu_reg_ip;
        z80fi_reg_a_in     <= c_a_in;
        z80fi_reg_a_out    <= cpu_reg_a;
        z80fi_reg_r_in     <= c_r_in;
        z80fi_reg_r_out    <= cpu_reg_r;
        z80fi_mcycle_type1 <= c_type[0];
        z80fi_mcycle_type2 <= c_type[1];
        z80fi_mcycle_type3 <= c_type[2];
        z80fi_tcycles1     <= c_tc[0];
        z80fi_tcycles2     <= c_tc[1];
        z80fi_tcycles3     <= c_tc[2];
        z80fi_overflow     <= c_ovf;
      end
    end
  end

endmodule

// File: tb/tb_z80fi_insn_tracker.sv
// Scoreboard bench for z80fi_insn_tracker: expected records are queued as each instruction ends
// and compared field by field when z80fi_valid fires, including the two-clock latency.
module tb_z80fi_insn_tracker;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_M1   = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        insn_start = 1'b0, insn_end = 1'b0, mcycle_start = 1'b0;
  logic [2:0]  mcycle_type = 3'd0;
  logic        tstate = 1'b0, fetch_valid = 1'b0;
  logic [7:0]  fetch_byte = 8'd0;
  logic [15:0] reg_ip = 16'd0;
  logic [7:0]  reg_a = 8'd0, reg_r = 8'd0;

  logic        valid, overflow;
  logic [31:0] insn;
  logic [2:0]  insn_len, type1, type2, type3;
  logic [15:0] ip_in, ip_out;
  logic [7:0]  a_in, a_out, r_in, r_out;
  logic [3:0]  tc1, tc2, tc3;

  z80fi_insn_tracker dut (
    .clk(clk), .reset_n(rst_n),
    .cpu_insn_start(insn_start), .cpu_insn_end(insn_end),
    .cpu_mcycle_start(mcycle_start), .cpu_mcycle_type(mcycle_type),
    .cpu_tstate(tstate), .cpu_fetch_valid(fetch_valid), .cpu_fetch_byte(fetch_byte),
    .cpu_reg_ip(reg_ip), .cpu_reg_a(reg_a), .cpu_reg_r(reg_r),
    .z80fi_valid(valid), .z80fi_insn(insn), .z80fi_insn_len(insn_len),
    .z80fi_reg_ip_in(ip_in), .z80fi_reg_ip_out(ip_out),
    .z80fi_reg_a_in(a_in), .z80fi_reg_a_out(a_out),
    .z80fi_reg_r_in(r_in), .z80fi_reg_r_out(r_out),
    .z80fi_mcycle_type1(type1), .z80fi_mcycle_type2(type2), .z80fi_mcycle_type3(type3),
    .z80fi_tcycles1(tc1), .z80fi_tcycles2(tc2), .z80fi_tcycles3(tc3),
    .z80fi_overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [2:0]  len;
    logic [15:0] ip_in, ip_out;
    logic [7:0]  a_in, a_out, r_in, r_out;
    logic [2:0]  ty1, ty2, ty3;
    logic [3:0]  c1, c2, c3;
    logic        ovf;
    int          cyc;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        rec_t e;
        e = q.pop_front();
        check("latency",  cyc_n,    e.cyc + 2);
        check("insn",     insn,     e.insn);
        check("len",      insn_len, e.len);
        check("ip_in",    ip_in,    e.ip_in);
        check("ip_out",   ip_out,   e.ip_out);
        check("a_in",     a_in,     e.a_in);
        check("a_out",    a_out,    e.a_out);
        check("r_in",     r_in,     e.r_in);
        check("r_out",    r_out,    e.r_out);
        check("type1",    type1,    e.ty1);
        check("type2",    type2,    e.ty2);
        check("type3",    type3,    e.ty3);
        check("tcycles1", tc1,      e.c1);
        check("tcycles2", tc2,      e.c2);
        check("tcycles3", tc3,      e.c3);
        check("overflow", overflow, e.ovf);
      end
    end
  end

  task automatic step(input logic st, input logic en, input logic ms, input logic [2:0] mt,
                      input logic ts, input logic fv, input logic [7:0] fb);
    insn_start = st; insn_end = en; mcycle_start = ms; mcycle_type = mt;
    tstate = ts; fetch_valid = fv; fetch_byte = fb;
    last_cyc = cyc_n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
  endtask

  // One M-cycle of nt T-states; optional fetch in its second T-state, optional end in its last.
  task automatic mcyc(input logic st, input logic [2:0] mt, input int nt,
                      input logic fv, input logic [7:0] fb, input logic en);
    for (int i = 0; i < nt; i++)
      step(st && i == 0, en && i == nt - 1, i == 0, (i == 0) ? mt : 3'd0, 1'b1, fv && i == 1, fb);
  endtask

  task automatic expect_rec(input logic [31:0] ins, input logic [2:0] len,
                            input logic [15:0] ipi, input logic [15:0] ipo,
                            input logic [7:0] ai, input logic [7:0] ao,
                            input logic [7:0] ri, input logic [7:0] ro,
                            input logic [2:0] t1, input logic [2:0] t2, input logic [2:0] t3,
                            input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                            input logic ovf);
    rec_t e;
    e.insn = ins; e.len = len; e.ip_in = ipi; e.ip_out = ipo;
    e.a_in = ai; e.a_out = ao; e.r_in = ri; e.r_out = ro;
    e.ty1 = t1; e.ty2 = t2; e.ty3 = t3; e.c1 = c1; e.c2 = c2; e.c3 = c3;
    e.ovf = ovf; e.cyc = last_cyc;
    q.push_back(e);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_insn", insn, 32'h0);
    check("rst_len", insn_len, 3'd0);
    check("rst_type1", type1, C_NONE);
    check("rst_tc1", tc1, 4'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // LD R,A: ED 4F, M1 4T + M1 5T.
    reg_ip = 16'h1000; reg_a = 8'h5A; reg_r = 8'h10;
    mcyc(1'b1, C_M1, 4, 1'b1, 8'hED, 1'b0);
    mcyc(1'b0, C_M1, 5, 1'b1, 8'h4F, 1'b1);
    reg_ip = 16'h1002; reg_r = 8'h5A;
    expect_rec(32'h00004FED, 3'd2, 16'h1000, 16'h1002, 8'h5A, 8'h5A, 8'h10, 8'h5A,
               C_M1, C_M1, C_NONE, 4'd4, 4'd5, 4'd0, 1'b0);
    idle(4);

    // NOP then LD R,A back-to-back: end and start share one cycle.
    reg_ip = 16'h2000; reg_a = 8'h33; reg_r = 8'h07;
    mcyc(1'b1, C_M1, 3, 1'b1, 8'h00, 1'b0);
    reg_ip = 16'h2001;
    step(1'b1, 1'b1, 1'b1, C_M1, 1'b1, 1'b0, 8'h00);
    expect_rec(32'h0, 3'd1, 16'h2000, 16'h2001, 8'h33, 8'h33, 8'h07, 8'h07,
               C_M1, C_NONE, C_NONE, 4'd4, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'hED);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
    mcyc(1'b0, C_M1, 5, 1'b1, 8'h4F, 1'b1);
    reg_ip = 16'h2003; reg_r = 8'h33;
    expect_rec(32'h00004FED, 3'd2, 16'h2001, 16'h2003, 8'h33, 8'h33, 8'h07, 8'h33,
               C_M1, C_M1, C_NONE, 4'd4, 4'd5, 4'd0, 1'b0);
    idle(4);

    // Five fetched bytes: fifth dropped, overflow set.
    reg_ip = 16'h3000; reg_a = 8'h11; reg_r = 8'h20;
    mcyc(1'b1, C_M1, 4, 1'b1, 8'hDD, 1'b0);
    mcyc(1'b0, C_RD, 3, 1'b1, 8'hCB, 1'b0);
    mcyc(1'b0, C_RD, 3, 1'b1, 8'h12, 1'b0);
    mcyc(1'b0, C_RD, 3, 1'b1, 8'h34, 1'b0);
    mcyc(1'b0, C_RD, 3, 1'b1, 8'h56, 1'b1);
    reg_ip = 16'h3005;
    expect_rec(32'h3412CBDD, 3'd4, 16'h3000, 16'h3005, 8'h11, 8'h11, 8'h20, 8'h20,
               C_M1, C_RD, C_RD, 4'd4, 4'd3, 4'd3, 1'b1);
    idle(4);

    // Five M-cycles, 20 T-states in slot 2: only 3 slots reported, count saturates, no overflow.
    reg_ip = 16'h4000; reg_a = 8'h01; reg_r = 8'h02;
    mcyc(1'b1, C_M1, 4, 1'b1, 8'h76, 1'b0);
    mcyc(1'b0, C_RD, 20, 1'b0, 8'h00, 1'b0);
    mcyc(1'b0, C_WR, 3, 1'b0, 8'h00, 1'b0);
    mcyc(1'b0, C_RD, 3, 1'b0, 8'h00, 1'b0);
    mcyc(1'b0, C_WR, 3, 1'b0, 8'h00, 1'b1);
    reg_ip = 16'h4001;
    expect_rec(32'h00000076, 3'd1, 16'h4000, 16'h4001, 8'h01, 8'h01, 8'h02, 8'h02,
               C_M1, C_RD, C_WR, 4'd4, 4'd15, 4'd3, 1'b0);
    idle(4);

    // Reset while ACTIVE after one byte: no record, outputs back to reset values.
    reg_ip = 16'h5000; reg_a = 8'h44; reg_r = 8'h55;
    step(1'b1, 1'b0, 1'b1, C_M1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'hAB);
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    check("midrst_insn", insn, 32'h0);
    check("midrst_type2", type2, C_NONE);
    check("midrst_tc2", tc2, 4'd0);
    check("midrst_ip_out", ip_out, 16'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1);
    mcyc(1'b1, C_M1, 4, 1'b1, 8'h00, 1'b1);
    reg_ip = 16'h5001;
    expect_rec(32'h0, 3'd1, 16'h5000, 16'h5001, 8'h44, 8'h44, 8'h55, 8'h55,
               C_M1, C_NONE, C_NONE, 4'd4, 4'd0, 4'd0, 1'b0);
    idle(4);

    // Start twice without end: first record aborted with overflow, second normal.
    reg_ip = 16'h6000; reg_a = 8'h66; reg_r = 8'h77;
    mcyc(1'b1, C_M1, 4, 1'b1, 8'hC9, 1'b0);
    step(1'b1, 1'b0, 1'b1, C_M1, 1'b0, 1'b0, 8'h00);
    expect_rec(32'h000000C9, 3'd1, 16'h6000, 16'h6000, 8'h66, 8'h66, 8'h77, 8'h77,
               C_M1, C_NONE, C_NONE, 4'd4, 4'd0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
    reg_ip = 16'h6001;
    expect_rec(32'h0, 3'd1, 16'h6000, 16'h6001, 8'h66, 8'h66, 8'h77, 8'h77,
               C_M1, C_NONE, C_NONE, 4'd4, 4'd0, 4'd0, 1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    idle(2);
    check("drain", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
